// File: rtl/cac_tx_arbiter.sv
// cac_tx_arbiter: round-robin arbiter that lets NUM_REQ packet sources share
// one CAC UART transmitter. A winner owns the transmitter for a whole packet
// (until req_last), or until it stalls for TIMEOUT_CYCLES cycles, and its
// bytes pass through a single registered output buffer.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester byte-present flags
//   req_data       packed requester bytes, slice i = requester i
//   req_last       per-requester last-byte-of-packet flags
//   req_ready      per-requester accept strobe (combinational, one-hot or zero)
//   tx_data        byte presented to the UART transmitter
//   tx_valid       tx_data holds a byte
//   tx_ready       transmitter accepts tx_data this cycle
//   grant          one-hot current owner, zero when idle
//   timeout_pulse  one-cycle pulse when the owner is aborted for stalling
module cac_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            timeout_pulse
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [CNT_W-1:0]        stall_q, stall_d;
    logic                    timeout_q, timeout_d;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    owner_valid;
    logic                    owner_last;
    logic                    buf_open;
    logic                    xfer;
    logic                    drain;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_owner_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Owner's byte/flags, selected by comparison to keep part-selects constant.
    always_comb begin
        owner_data  = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
            end
        end
    end

    // Buffer can take a byte when empty or being emptied this cycle.
    assign buf_open  = !tx_valid_q || tx_ready;
    assign req_ready = (state_q == ST_SEND && buf_open) ? grant_q : '0;
    assign xfer      = (state_q == ST_SEND) && owner_valid && buf_open;
    assign drain     = tx_valid_q && tx_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        stall_d      = stall_q;
        timeout_d    = 1'b0;

        // A load wins over a drain in the same cycle, keeping tx_valid high.
        if (xfer) begin
            tx_data_d  = owner_data;
            tx_valid_d = 1'b1;
        end else if (drain) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    stall_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) begin
                    stall_d = '0;
                    if (owner_last) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!owner_valid) begin
                    // Only an absent owner counts; tx backpressure never does.
                    if (stall_q == STALL_LIMIT) begin
                        state_d   = ST_DRAIN;
                        timeout_d = 1'b1;
                    end else begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (buf_open) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            grant_q      <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            stall_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            stall_q      <= stall_d;
            timeout_q    <= timeout_d;
        end
    end

    assign grant         = grant_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_cac_tx_arbiter.sv
// Directed bench for cac_tx_arbiter (NUM_REQ=4, DATA_WIDTH=8, TIMEOUT_CYCLES=16).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_cac_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        timeout_pulse;

    int n_cmp = 0;
    int n_err = 0;

    cac_tx_arbiter #(
        .NUM_REQ        (4),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        tick();
        chk("rst_grant",   32'(grant), 0);
        chk("rst_txvalid", 32'(tx_valid), 0);
        chk("rst_txdata",  32'(tx_data), 0);
        chk("rst_timeout", 32'(timeout_pulse), 0);
        chk("rst_ready",   32'(req_ready), 0);
        rst = 1'b0;

        // req0 sends 10,01,11(last) with tx_ready high
        tx_ready = 1'b1;
        req_valid = 4'b0001; req_data[7:0] = 8'h10;
        tick();
        chk("s1_grant", 32'(grant), 32'h1);
        chk("s1_txvalid0", 32'(tx_valid), 0);
        chk("s1_ready", 32'(req_ready), 32'h1);
        tick();
        chk("s1_b0", 32'(tx_data), 32'h10);
        chk("s1_v0", 32'(tx_valid), 1);
        req_data[7:0] = 8'h01;
        tick();
        chk("s1_b1", 32'(tx_data), 32'h01);
        req_data[7:0] = 8'h11; req_last = 4'b0001;
        tick();
        chk("s1_b2", 32'(tx_data), 32'h11);
        chk("s1_drain_grant", 32'(grant), 32'h1);
        chk("s1_drain_ready", 32'(req_ready), 0);
        req_valid = '0; req_last = '0;
        tick();
        chk("s1_end_grant", 32'(grant), 0);
        chk("s1_end_txvalid", 32'(tx_valid), 0);

        // req0 and req2 contend right after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s2_rst_grant", 32'(grant), 0);
        req_valid = 4'b0101; req_last = 4'b0101;
        req_data[7:0] = 8'hA0; req_data[23:16] = 8'hC0;
        tick();
        chk("s2_g0", 32'(grant), 32'h1);
        tick();
        chk("s2_a0", 32'(tx_data), 32'hA0);
        chk("s2_a0v", 32'(tx_valid), 1);
        req_valid = 4'b0100;
        tick();
        chk("s2_gap0", 32'(grant), 0);
        chk("s2_gap0v", 32'(tx_valid), 0);
        tick();
        chk("s2_g2", 32'(grant), 32'h4);
        chk("s2_r2", 32'(req_ready), 32'h4);
        tick();
        chk("s2_c0", 32'(tx_data), 32'hC0);
        req_valid = 4'b0101; req_data[7:0] = 8'hA1; req_data[23:16] = 8'hC1;
        tick();
        chk("s2_gap1", 32'(grant), 0);
        chk("s2_gap1r", 32'(req_ready), 0);
        tick();
        chk("s2_g0b", 32'(grant), 32'h1);
        tick();
        chk("s2_a1", 32'(tx_data), 32'hA1);
        req_valid = 4'b0100;
        tick();
        tick();
        chk("s2_g2b", 32'(grant), 32'h4);
        tick();
        chk("s2_c1", 32'(tx_data), 32'hC1);
        req_valid = '0; req_last = '0;
        tick();
        chk("s2_end", 32'(grant), 0);

        // req1 under 20 cycles of tx backpressure: no timeout
        tx_ready = 1'b0;
        req_valid = 4'b0010; req_data[15:8] = 8'h30;
        tick();
        chk("s3_g1", 32'(grant), 32'h2);
        chk("s3_r1", 32'(req_ready), 32'h2);
        tick();
        chk("s3_b30", 32'(tx_data), 32'h30);
        chk("s3_v30", 32'(tx_valid), 1);
        req_data[15:8] = 8'h31;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("s3_hold_data", 32'(tx_data), 32'h30);
            chk("s3_hold_valid", 32'(tx_valid), 1);
            chk("s3_hold_ready", 32'(req_ready), 0);
            chk("s3_hold_timeout", 32'(timeout_pulse), 0);
        end
        tx_ready = 1'b1;
        #1;
        chk("s3_ready_open", 32'(req_ready), 32'h2);
        tick();
        chk("s3_b31", 32'(tx_data), 32'h31);
        chk("s3_v31", 32'(tx_valid), 1);
        req_data[15:8] = 8'h32; req_last = 4'b0010;
        tick();
        chk("s3_b32", 32'(tx_data), 32'h32);
        req_valid = '0; req_last = '0;
        tick();
        chk("s3_end_grant", 32'(grant), 0);
        chk("s3_end_valid", 32'(tx_valid), 0);

        // req3 sends one byte then goes silent; req0 waits
        req_valid = 4'b1000; req_data[31:24] = 8'h5A;
        tick();
        chk("s4_g3", 32'(grant), 32'h8);
        tick();
        chk("s4_b5a", 32'(tx_data), 32'h5A);
        req_valid = 4'b0001; req_data[7:0] = 8'h77; req_last = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("s4_no_timeout", 32'(timeout_pulse), 0);
            chk("s4_hold_grant", 32'(grant), 32'h8);
        end
        tick();
        chk("s4_timeout", 32'(timeout_pulse), 1);
        chk("s4_drain_grant", 32'(grant), 32'h8);
        tick();
        chk("s4_pulse_end", 32'(timeout_pulse), 0);
        chk("s4_grant_clr", 32'(grant), 0);
        tick();
        chk("s4_g0", 32'(grant), 32'h1);
        tick();
        chk("s4_b77", 32'(tx_data), 32'h77);
        req_valid = '0; req_last = '0;
        tick();

        // reset mid-packet while the buffer is full
        tx_ready = 1'b0;
        req_valid = 4'b0100; req_data[23:16] = 8'hE1;
        tick();
        chk("s5_g2", 32'(grant), 32'h4);
        tick();
        chk("s5_full", 32'(tx_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_rst_valid", 32'(tx_valid), 0);
        chk("s5_rst_grant", 32'(grant), 0);
        chk("s5_rst_data", 32'(tx_data), 0);
        tick();
        chk("s5_g2b", 32'(grant), 32'h4);
        tx_ready = 1'b1;
        tick();
        chk("s5_be1", 32'(tx_data), 32'hE1);
        req_data[23:16] = 8'hE2; req_last = 4'b0100;
        tick();
        chk("s5_be2", 32'(tx_data), 32'hE2);
        req_valid = '0; req_last = '0;
        tick();
        chk("s5_end", 32'(grant), 0);

        // req3 single-byte packet while req1 waits
        req_valid = 4'b1010; req_last = 4'b1010;
        req_data[31:24] = 8'hA5; req_data[15:8] = 8'h11;
        tick();
        chk("s6_g3", 32'(grant), 32'h8);
        chk("s6_r3", 32'(req_ready), 32'h8);
        tick();
        chk("s6_ba5", 32'(tx_data), 32'hA5);
        chk("s6_drain_ready", 32'(req_ready), 0);
        req_valid = 4'b0010;
        tick();
        chk("s6_gap_valid", 32'(tx_valid), 0);
        chk("s6_gap_grant", 32'(grant), 0);
        tick();
        chk("s6_g1", 32'(grant), 32'h2);
        tick();
        chk("s6_b11", 32'(tx_data), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
